// File: rtl/down_mixer_acc.sv
// Complex down-mixer with windowed integration: three-stage multiply/sum/accumulate
// pipeline, then an arithmetic shift and saturation of the accumulated I/Q result.
module down_mixer_acc #(
  parameter int INPUT_WIDTH  = 16,
  parameter int OUTPUT_WIDTH = 16,
  parameter int CNT_WIDTH    = 10,
  parameter int OUT_SHIFT    = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [CNT_WIDTH-1:0]           acc_len,
  input  logic                           mode,
  input  logic                           in_valid,
  input  logic signed [INPUT_WIDTH-1:0]  i_in_1,
  input  logic signed [INPUT_WIDTH-1:0]  q_in_1,
  input  logic signed [INPUT_WIDTH-1:0]  i_in_2,
  input  logic signed [INPUT_WIDTH-1:0]  q_in_2,
  output logic                           busy,
  output logic                           out_valid,
  output logic signed [OUTPUT_WIDTH-1:0] i_out,
  output logic signed [OUTPUT_WIDTH-1:0] q_out,
  output logic                           sat_flag
);

  localparam int ACC_WIDTH = 2*INPUT_WIDTH + 1 + CNT_WIDTH;
  localparam int PROD_W    = 2*INPUT_WIDTH;
  localparam int SUM_W     = PROD_W + 1;

  localparam logic signed [ACC_WIDTH-1:0] MAX_V =
    {{(ACC_WIDTH-OUTPUT_WIDTH+1){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] MIN_V =
    {{(ACC_WIDTH-OUTPUT_WIDTH+1){1'b1}}, {(OUTPUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t                       r_state;
  logic [CNT_WIDTH-1:0]         r_left;
  logic                         r_mode;
  logic                         r_s1_vld, r_s1_last;
  logic signed [PROD_W-1:0]     r_p_ii, r_p_qq, r_p_iq, r_p_qi;
  logic                         r_s2_vld, r_s2_last;
  logic signed [SUM_W-1:0]      r_sum_i, r_sum_q;
  logic                         r_s3_last;
  logic signed [ACC_WIDTH-1:0]  r_acc_i, r_acc_q;

  logic                         w_accept, w_last;
  logic signed [PROD_W-1:0]     w_p_ii, w_p_qq, w_p_iq, w_p_qi;
  logic signed [ACC_WIDTH-1:0]  w_sh_i, w_sh_q;
  logic signed [OUTPUT_WIDTH-1:0] w_out_i, w_out_q;
  logic                         w_clip_i, w_clip_q;

  assign busy     = (r_state != S_IDLE);
  assign w_accept = (r_state == S_ACC) && in_valid;
  assign w_last   = w_accept && (r_left == CNT_WIDTH'(1));

  assign w_p_ii = PROD_W'(i_in_1) * PROD_W'(i_in_2);
  assign w_p_qq = PROD_W'(q_in_1) * PROD_W'(q_in_2);
  assign w_p_iq = PROD_W'(i_in_1) * PROD_W'(q_in_2);
  assign w_p_qi = PROD_W'(q_in_1) * PROD_W'(i_in_2);

  assign w_sh_i = r_acc_i >>> OUT_SHIFT;
  assign w_sh_q = r_acc_q >>> OUT_SHIFT;

  always_comb begin
    w_out_i  = w_sh_i[OUTPUT_WIDTH-1:0];
    w_clip_i = 1'b0;
    if (w_sh_i > MAX_V) begin
      w_out_i  = MAX_V[OUTPUT_WIDTH-1:0];
      w_clip_i = 1'b1;
    end else if (w_sh_i < MIN_V) begin
      w_out_i  = MIN_V[OUTPUT_WIDTH-1:0];
      w_clip_i = 1'b1;
    end
  end

  always_comb begin
    w_out_q  = w_sh_q[OUTPUT_WIDTH-1:0];
    w_clip_q = 1'b0;
    if (w_sh_q > MAX_V) begin
      w_out_q  = MAX_V[OUTPUT_WIDTH-1:0];
      w_clip_q = 1'b1;
    end else if (w_sh_q < MIN_V) begin
      w_out_q  = MIN_V[OUTPUT_WIDTH-1:0];
      w_clip_q = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_left    <= '0;
      r_mode    <= 1'b0;
      r_s1_vld  <= 1'b0;
      r_s1_last <= 1'b0;
      r_p_ii    <= '0;
      r_p_qq    <= '0;
      r_p_iq    <= '0;
      r_p_qi    <= '0;
      r_s2_vld  <= 1'b0;
      r_s2_last <= 1'b0;
      r_sum_i   <= '0;
      r_sum_q   <= '0;
      r_s3_last <= 1'b0;
      r_acc_i   <= '0;
      r_acc_q   <= '0;
      out_valid <= 1'b0;
      i_out     <= '0;
      q_out     <= '0;
      sat_flag  <= 1'b0;
    end else begin
      out_valid <= 1'b0;

      r_s1_vld  <= w_accept;
      r_s1_last <= w_last;
      if (w_accept) begin
        r_p_ii <= w_p_ii;
        r_p_qq <= w_p_qq;
        r_p_iq <= w_p_iq;
        r_p_qi <= w_p_qi;
      end

      r_s2_vld  <= r_s1_vld;
      r_s2_last <= r_s1_last;
      if (r_s1_vld) begin
        if (r_mode) begin
          r_sum_i <= SUM_W'(r_p_ii) - SUM_W'(r_p_qq);
          r_sum_q <= SUM_W'(r_p_iq) + SUM_W'(r_p_qi);
        end else begin
          r_sum_i <= SUM_W'(r_p_ii) + SUM_W'(r_p_qq);
          r_sum_q <= SUM_W'(r_p_iq) - SUM_W'(r_p_qi);
        end
      end

      r_s3_last <= r_s2_vld && r_s2_last;
      if (r_s2_vld) begin
        r_acc_i <= r_acc_i + ACC_WIDTH'(r_sum_i);
        r_acc_q <= r_acc_q + ACC_WIDTH'(r_sum_q);
      end

      case (r_state)
        S_IDLE: begin
          // pipeline is drained whenever IDLE is reached, so clearing here is safe
          if (start) begin
            r_left  <= (acc_len == '0) ? CNT_WIDTH'(1) : acc_len;
            r_mode  <= mode;
            r_acc_i <= '0;
            r_acc_q <= '0;
            r_state <= S_ACC;
          end
        end
        S_ACC: begin
          if (w_accept) begin
            r_left <= r_left - CNT_WIDTH'(1);
            if (w_last) r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_s3_last) begin
            i_out     <= w_out_i;
            q_out     <= w_out_q;
            sat_flag  <= w_clip_i || w_clip_q;
            out_valid <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_down_mixer_acc.sv
// Scoreboard bench for down_mixer_acc: randomized windows against an arithmetic
// reference of the integrated complex product, with a decoupled output monitor.
module tb_down_mixer_acc;

  logic               clk, rst, start, mode, in_valid;
  logic [9:0]         acc_len;
  logic signed [15:0] i_in_1, q_in_1, i_in_2, q_in_2;
  logic               busy, out_valid, sat_flag;
  logic signed [15:0] i_out, q_out;

  down_mixer_acc dut (
    .clk(clk), .rst(rst), .start(start), .acc_len(acc_len), .mode(mode),
    .in_valid(in_valid), .i_in_1(i_in_1), .q_in_1(q_in_1), .i_in_2(i_in_2),
    .q_in_2(q_in_2), .busy(busy), .out_valid(out_valid), .i_out(i_out),
    .q_out(q_out), .sat_flag(sat_flag)
  );

  typedef struct {
    longint ei;
    longint eq;
    longint esat;
    int     ecyc;
  } exp_t;

  exp_t   sb[$];
  bit     vpat[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  longint hold_i = 0, hold_q = 0, hold_s = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  function automatic longint clamp(longint v, output bit c);
    c = 1'b0;
    if (v > 32767) begin c = 1'b1; return 32767; end
    if (v < -32768) begin c = 1'b1; return -32768; end
    return v;
  endfunction

  // monitor: every result strobe must match the oldest expected window, else outputs hold
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) continue;
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("i_out", i_out, e.ei);
          chk("q_out", q_out, e.eq);
          chk("sat_flag", sat_flag, e.esat);
          chk("out_valid_cycle", cyc, e.ecyc);
          hold_i = e.ei; hold_q = e.eq; hold_s = e.esat;
        end
      end else begin
        chk("hold_i", i_out, hold_i);
        chk("hold_q", q_out, hold_q);
        chk("hold_sat", sat_flag, hold_s);
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic drive_data(input bit fixed, input logic signed [15:0] a, b, c, d);
    if (fixed) begin
      i_in_1 = a; q_in_1 = b; i_in_2 = c; q_in_2 = d;
    end else begin
      i_in_1 = 16'($urandom); q_in_1 = 16'($urandom);
      i_in_2 = 16'($urandom); q_in_2 = 16'($urandom);
    end
  endtask

  task automatic idle_gap(input int n);
    repeat (n) begin
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'($urandom);
      drive_data(0, 0, 0, 0, 0);
    end
  endtask

  task automatic feed(input bit m, input int len, input bit fixed,
                      input logic signed [15:0] a, b, c, d, input bit mid_start);
    int eff, n, g;
    bit v, ci, cq;
    longint ai, aq, pii, pqq, piq, pqi;
    exp_t e;
    eff = (len == 0) ? 1 : len;
    @(negedge clk);
    start = 1'b1; acc_len = 10'(len); mode = m;
    in_valid = 1'($urandom);
    drive_data(0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("busy_after_start", busy, 1);
    n = 0; g = 0; ai = 0; aq = 0;
    while (n < eff && g < 5000) begin
      @(negedge clk);
      start   = mid_start && (g == 1);
      acc_len = 10'($urandom);
      mode    = 1'($urandom);
      v = (vpat.size() > 0) ? vpat.pop_front() : ($urandom_range(0, 99) < 70);
      in_valid = v;
      drive_data(fixed, a, b, c, d);
      if (v) begin
        pii = longint'(i_in_1) * longint'(i_in_2);
        pqq = longint'(q_in_1) * longint'(q_in_2);
        piq = longint'(i_in_1) * longint'(q_in_2);
        pqi = longint'(q_in_1) * longint'(i_in_2);
        if (m) begin ai += pii - pqq; aq += piq + pqi; end
        else   begin ai += pii + pqq; aq += piq - pqi; end
        n++;
      end
      @(posedge clk);
      #1;
      g++;
    end
    if (n < eff) chk("window_timeout", n, eff);
    e.ei   = clamp(ai >>> 16, ci);
    e.eq   = clamp(aq >>> 16, cq);
    e.esat = longint'(ci | cq);
    e.ecyc = cyc + 3;
    sb.push_back(e);
    repeat (3) begin
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'($urandom);
      drive_data(0, 0, 0, 0, 0);
      @(posedge clk);
    end
    #1;
    chk("busy_after_result", busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; in_valid = 1'b0; acc_len = '0;
    i_in_1 = '0; q_in_1 = '0; i_in_2 = '0; q_in_2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_i_out", i_out, 0);
    chk("rst_sat", sat_flag, 0);
    rst = 1'b0;
    idle_gap(3);

    vpat = '{1};
    feed(0, 1, 1, 16384, 0, 16384, 0, 0);
    vpat = '{1, 1, 1, 1};
    feed(1, 4, 1, 8192, 8192, 8192, 8192, 0);
    feed(0, 4, 1, -32768, -32768, -32768, -32768, 0);
    vpat = '{1, 0, 1, 0, 0, 1};
    feed(0, 3, 0, 0, 0, 0, 0, 1);
    feed(0, 8, 1, 32767, 0, -32768, 0, 0);
    feed(1, 2, 1, -32768, -32768, -32768, -32768, 0);

    // reset in the middle of a 4-sample window
    @(negedge clk);
    start = 1'b1; acc_len = 10'd4; mode = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) begin
      in_valid = 1'b1;
      drive_data(1, 20000, 20000, 20000, 20000);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    hold_i = 0; hold_q = 0; hold_s = 0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_i_out", i_out, 0);
    chk("midrst_q_out", q_out, 0);
    chk("midrst_sat", sat_flag, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle_gap(6);
    vpat = '{1};
    feed(0, 0, 1, 1000, -2000, 3000, 4000, 0);

    for (int k = 0; k < 25; k++) begin
      if ($urandom_range(0, 3) == 0) idle_gap($urandom_range(1, 4));
      feed(1'($urandom), $urandom_range(0, 40), 0, 0, 0, 0, 0, 1'($urandom));
    end

    repeat (10) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
